// File: rtl/mac_stream_engine.sv
// Single-lane signed multiply-accumulate engine: runtime vector length, valid/ready streaming,
// round-half-up realignment and saturation. done_o is a combinational pulse on the last handshake.
module mac_stream_engine #(
  parameter int unsigned DATA_W    = 20,
  parameter int unsigned OUT_W     = 24,
  parameter int unsigned LEN_W     = 11,
  parameter int unsigned OUT_SHIFT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [1:0]               op_mode_i,
  input  logic [LEN_W-1:0]         vec_len_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] in1_i,
  input  logic signed [DATA_W-1:0] in2_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [OUT_W-1:0]  out_o,
  output logic                     sat_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = 2 * DATA_W + LEN_W;

  localparam logic signed [ACC_W-1:0] RndConst =
      (OUT_SHIFT == 0) ? '0 : (ACC_W'(1) << (OUT_SHIFT - 1));
  localparam logic signed [ACC_W-1:0] OutMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OutMin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StOut, StFlush} state_e;
  typedef enum logic [1:0] {ModeDot, ModeSq, ModeScale, ModeColsum} mode_e;

  state_e                   state_q, state_d;
  mode_e                    mode_q, mode_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         ocnt_q, ocnt_d;
  logic signed [PROD_W-1:0] p1_q, p1_d;
  logic                     p1_vld_q, p1_vld_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     acc_first_q, acc_first_d;
  logic signed [OUT_W-1:0]  out_q, out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_q, sat_d;

  logic                     is_scale, out_free, in_ready, in_fire, out_fire, last_out, p1_take;
  logic [LEN_W-1:0]         cnt_inc, ocnt_inc;
  logic signed [PROD_W-1:0] in1_ext, in2_ext, prod;
  logic signed [ACC_W-1:0]  p1_ext, src, biased, shifted;
  logic signed [OUT_W-1:0]  res;
  logic                     res_sat;

  assign is_scale = (mode_q == ModeScale);
  assign out_free = !out_valid_q || out_ready_i;
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign ocnt_inc = ocnt_q + LEN_W'(1);

  // Counter stops at len_q, so a full 2**LEN_W-1 job never wraps it.
  assign in_ready = (state_q == StRun) && (cnt_q != len_q) && (!is_scale || out_free);
  assign in_fire  = in_valid_i && in_ready;
  assign out_fire = out_valid_q && out_ready_i;
  assign last_out = (state_q == StOut) || (state_q == StFlush) ||
                    ((state_q == StRun) && is_scale && (ocnt_inc == len_q));
  // Accumulating modes drain stage 1 every cycle; SCALE only when the output slot frees.
  assign p1_take  = p1_vld_q && (!is_scale || out_free);

  assign in1_ext = {{DATA_W{in1_i[DATA_W-1]}}, in1_i};
  assign in2_ext = {{DATA_W{in2_i[DATA_W-1]}}, in2_i};
  assign p1_ext  = {{LEN_W{p1_q[PROD_W-1]}}, p1_q};

  always_comb begin
    prod = '0;
    unique case (mode_q)
      ModeSq:     prod = in1_ext * in1_ext;
      ModeColsum: prod = in1_ext;
      default:    prod = in1_ext * in2_ext;
    endcase
  end

  // Realign, round half up and clip the value headed for the output register.
  always_comb begin
    src     = is_scale ? p1_ext : acc_q;
    biased  = src + RndConst;
    shifted = (mode_q == ModeColsum) ? src : (biased >>> OUT_SHIFT);
    res     = shifted[OUT_W-1:0];
    res_sat = 1'b0;
    if (shifted > OutMax) begin
      res     = OutMax[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (shifted < OutMin) begin
      res     = OutMin[OUT_W-1:0];
      res_sat = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ocnt_d      = ocnt_q;
    p1_d        = p1_q;
    p1_vld_d    = p1_vld_q;
    acc_d       = acc_q;
    acc_first_d = acc_first_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;

    if (in_fire) begin
      p1_d     = prod;
      p1_vld_d = 1'b1;
      cnt_d    = cnt_inc;
    end else if (p1_take) begin
      p1_vld_d = 1'b0;
    end

    // First element loads the accumulator, so no clear cycle is needed between jobs.
    if (p1_vld_q && !is_scale) begin
      acc_d       = acc_first_q ? p1_ext : acc_q + p1_ext;
      acc_first_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d      = mode_e'(op_mode_i);
          len_d       = vec_len_i;
          cnt_d       = '0;
          ocnt_d      = '0;
          sat_d       = 1'b0;
          acc_first_d = 1'b1;
          if (vec_len_i == '0) begin
            out_d       = '0;
            out_valid_d = 1'b1;
            state_d     = StFlush;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (is_scale) begin
          if (out_fire) begin
            ocnt_d = ocnt_inc;
            if (last_out) state_d = StIdle;
          end
          if (out_free) begin
            out_valid_d = p1_vld_q;
            if (p1_vld_q) begin
              out_d = res;
              sat_d = sat_q | res_sat;
            end
          end
        end else if (in_fire && (cnt_inc == len_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!p1_vld_q) begin
          out_d       = res;
          sat_d       = sat_q | res_sat;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end
      end
      StOut, StFlush: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mode_q      <= ModeDot;
      len_q       <= '0;
      cnt_q       <= '0;
      ocnt_q      <= '0;
      p1_q        <= '0;
      p1_vld_q    <= 1'b0;
      acc_q       <= '0;
      acc_first_q <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ocnt_q      <= ocnt_d;
      p1_q        <= p1_d;
      p1_vld_q    <= p1_vld_d;
      acc_q       <= acc_d;
      acc_first_q <= acc_first_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign sat_o       = sat_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = out_fire && last_out;

endmodule

// File: tb/tb_mac_stream_engine.sv
// Randomised bench for mac_stream_engine: job results come from an arithmetic model of the
// dot/square/scale/column-sum rules, with rounding, clipping and handshake timing checked.
module tb_mac_stream_engine;

  localparam int DATA_W = 20;
  localparam int OUT_W  = 24;
  localparam int LEN_W  = 11;
  localparam longint OMAX = 64'sd8388607;
  localparam longint OMIN = -64'sd8388608;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic [1:0]               op_mode = '0;
  logic [LEN_W-1:0]         vec_len = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in1 = '0;
  logic signed [DATA_W-1:0] in2 = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [OUT_W-1:0]  dout;
  logic                     sat;
  logic                     busy;
  logic                     done;

  int n_checks = 0;
  int n_errors = 0;

  int     a_q[$];
  int     b_q[$];
  longint exp_q[$];
  bit     exp_sat;

  mac_stream_engine #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .LEN_W(LEN_W), .OUT_SHIFT(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_mode_i(op_mode), .vec_len_i(vec_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in1_i(in1), .in2_i(in2),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_o(dout), .sat_o(sat),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rand_op();
    logic [DATA_W-1:0] t;
    t = DATA_W'($urandom);
    return int'($signed(t));
  endfunction

  function automatic longint clip(longint r);
    if (r > OMAX) begin exp_sat = 1'b1; return OMAX; end
    if (r < OMIN) begin exp_sat = 1'b1; return OMIN; end
    return r;
  endfunction

  function automatic longint rnd16(longint v);
    return (v + 64'sd32768) >>> 16;
  endfunction

  // mode: 0 dot, 1 square-sum, 2 per-element scale, 3 column sum of in1
  function automatic void build_expected(int mode, int len);
    longint acc = 0;
    exp_q.delete();
    exp_sat = 1'b0;
    if (len == 0) begin
      exp_q.push_back(0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      longint a = longint'(a_q[i]);
      longint b = longint'(b_q[i]);
      case (mode)
        0: acc += a * b;
        1: acc += a * a;
        2: exp_q.push_back(clip(rnd16(a * b)));
        default: acc += a;
      endcase
    end
    if (mode == 3) exp_q.push_back(clip(acc));
    else if (mode != 2) exp_q.push_back(clip(rnd16(acc)));
  endfunction

  // rdy_pct > 100 toggles out_ready every cycle
  task automatic run_job(input int mode, input int len, input int gap_pct, input int rdy_pct,
                         input string name);
    int     idx = 0, oidx = 0, first_acc = -1, last_acc = -1, first_ov = -1;
    bit     fin = 1'b0, stall = 1'b0;
    longint prev_out = 0;
    build_expected(mode, len);
    @(negedge clk);
    start    = 1'b1;
    op_mode  = 2'(mode);
    vec_len  = LEN_W'(len);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1 check_eq({name, "_busy_before_start"}, busy, 0);
    for (int c = 1; c <= 4 * len + 60 && !fin; c++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 9) == 0);
      op_mode = 2'($urandom);
      vec_len = LEN_W'($urandom);
      in_valid = (idx < len) && ($urandom_range(0, 99) >= gap_pct);
      in1 = in_valid ? DATA_W'(a_q[idx]) : DATA_W'($urandom);
      in2 = in_valid ? DATA_W'(b_q[idx]) : DATA_W'($urandom);
      out_ready = (rdy_pct > 100) ? (c % 2 == 1) : ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (stall) begin
        check_eq({name, "_hold_valid"}, out_valid, 1);
        check_eq({name, "_hold_data"}, dout, prev_out);
      end
      if (out_valid && first_ov < 0) begin
        first_ov = c;
        if (len == 0) check_eq({name, "_flush_latency"}, c, 1);
        else if (mode == 2) check_eq({name, "_scale_latency"}, c, first_acc + 2);
        else check_eq({name, "_acc_latency"}, c, last_acc + 3);
      end
      if (len == 0) check_eq({name, "_flush_in_ready"}, in_ready, 0);
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = c;
        if (idx == len - 1) last_acc = c;
        idx++;
      end
      if (out_valid && out_ready) begin
        if (oidx < exp_q.size()) check_eq({name, "_out"}, dout, exp_q[oidx]);
        else check_eq({name, "_extra_output"}, oidx, exp_q.size() - 1);
        check_eq({name, "_done_on_last"}, done, (oidx == exp_q.size() - 1));
        if (done) begin
          check_eq({name, "_sat"}, sat, exp_sat);
          fin = 1'b1;
        end
        oidx++;
      end else begin
        check_eq({name, "_done_idle"}, done, 0);
      end
      stall    = out_valid && !out_ready;
      prev_out = dout;
    end
    check_eq({name, "_finished_in_budget"}, fin, 1);
    check_eq({name, "_inputs_taken"}, idx, len);
    check_eq({name, "_outputs_taken"}, oidx, exp_q.size());
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq({name, "_busy_after"}, busy, 0);
    check_eq({name, "_valid_after"}, out_valid, 0);
  endtask

  task automatic fill_random(input int len);
    a_q.delete();
    b_q.delete();
    for (int i = 0; i < len; i++) begin
      a_q.push_back(rand_op());
      b_q.push_back(rand_op());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_sat", sat, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_out", dout, 0);
    @(negedge clk);
    rst = 1'b0;

    a_q.delete(); b_q.delete();
    for (int i = 0; i < 8; i++) begin a_q.push_back(256); b_q.push_back(256); end
    run_job(0, 8, 0, 100, "dot8");

    a_q.delete(); b_q.delete();
    for (int i = 0; i < 1152; i++) begin a_q.push_back(524287); b_q.push_back(rand_op()); end
    run_job(1, 1152, 0, 100, "sq1152");

    a_q.delete(); b_q.delete();
    for (int i = 0; i < 16; i++) begin a_q.push_back(i * 37 - 200); b_q.push_back(-65536); end
    run_job(2, 16, 0, 101, "scale16");

    a_q = '{-3, 5, 7, -1};
    b_q = '{0, 0, 0, 0};
    run_job(3, 4, 50, 100, "colsum4");

    a_q.delete(); b_q.delete();
    run_job(0, 0, 0, 60, "flush");

    // Abort a DOT job at element 5 of 8 and make sure nothing leaks into the next job.
    fill_random(8);
    @(negedge clk);
    start = 1'b1; op_mode = 2'd0; vec_len = LEN_W'(8);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in1 = DATA_W'(a_q[i]); in2 = DATA_W'(b_q[i]);
      @(negedge clk);
    end
    in1 = DATA_W'(a_q[5]); in2 = DATA_W'(b_q[5]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_sat", sat, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_out", dout, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    fill_random(8);
    run_job(0, 8, 20, 70, "after_abort");

    for (int j = 0; j < 24; j++) begin
      int m, l;
      m = $urandom_range(0, 3);
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30);
      fill_random(l);
      run_job(m, l, $urandom_range(0, 60), $urandom_range(30, 101), $sformatf("rnd%0d", j));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
